// File: rtl/spr16x2_arb_if.sv
// Requester-side command/response bundle for the SPR16X2 access controller.
// One instance per requester; the controller uses the slave view.
interface spr16x2_arb_if;
    logic       req;
    logic       we;
    logic [3:0] addr;
    logic [1:0] wdata;
    logic       gnt;
    logic       rvalid;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid
    );
endinterface

// File: rtl/spr16x2_arb.sv
// Two-requester access controller for one SPR16X2 single-port 16x2 RAM.
// Arbitrates A/B commands onto the single RAM port, registers every RAM
// drive, returns registered read data and optionally clears the RAM after
// reset before any grant is given.
module spr16x2_arb #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [1:0] CLEAR_DATA     = 2'b00,
    parameter string      ARB_MODE       = "RR"
) (
    input  logic              ck_i,
    input  logic              rstn_i,
    spr16x2_arb_if.slave      a_if,
    spr16x2_arb_if.slave      b_if,
    output logic [1:0]        rdata_o,
    output logic              busy_o,
    output logic [3:0]        ram_ad_o,
    output logic [1:0]        ram_di_o,
    output logic              ram_wre_o,
    output logic              ram_wpe_o,
    input  logic [1:0]        ram_do_i
);

    // FIXED mode: A always wins when both sides request.
    localparam bit FIXED_C = (ARB_MODE == "FIXED");

    typedef enum logic [0:0] {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam state_t RESET_STATE_C = CLEAR_ON_RESET ? ST_CLR : ST_RUN;

    // Grant selection: returns {gnt_b, gnt_a}. ptr_b=1 means B is favoured
    // on a tie. Nothing is granted unless the block is running.
    function automatic logic [1:0] pick_winner(
        input logic run,
        input logic req_a,
        input logic req_b,
        input logic ptr_b,
        input logic fixed
    );
        logic [1:0] g;
        g = 2'b00;
        if (!run) begin
            g = 2'b00;
        end else if (req_a && req_b) begin
            if (fixed || !ptr_b) begin
                g = 2'b01;
            end else begin
                g = 2'b10;
            end
        end else if (req_a) begin
            g = 2'b01;
        end else if (req_b) begin
            g = 2'b10;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    state_t     state_q,   state_d;
    logic [3:0] cnt_q,     cnt_d;
    logic       ptr_b_q,   ptr_b_d;
    logic [3:0] ram_ad_q,  ram_ad_d;
    logic [1:0] ram_di_q,  ram_di_d;
    logic       ram_wre_q, ram_wre_d;
    logic       ram_wpe_q, ram_wpe_d;
    logic       rd_a_q,    rd_a_d;
    logic       rd_b_q,    rd_b_d;
    logic       rvalid_a_q, rvalid_a_d;
    logic       rvalid_b_q, rvalid_b_d;
    logic [1:0] rdata_q,   rdata_d;

    logic [1:0] gnt_s;
    logic       xfer_a_s;
    logic       xfer_b_s;

    // Combinational grant; held low while reset is asserted and during clear.
    always_comb begin
        gnt_s    = pick_winner(rstn_i && (state_q == ST_RUN),
                               a_if.req, b_if.req, ptr_b_q, FIXED_C);
        xfer_a_s = a_if.req & gnt_s[0];
        xfer_b_s = b_if.req & gnt_s[1];
    end

    // Next-state logic: clear sequencer, RAM port drive, pointer and read pipe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_b_d    = ptr_b_q;
        ram_ad_d   = ram_ad_q;
        ram_di_d   = ram_di_q;
        ram_wre_d  = 1'b0;
        ram_wpe_d  = 1'b1;
        rd_a_d     = 1'b0;
        rd_b_d     = 1'b0;
        // A read issued last cycle has its address on the RAM now; its
        // asynchronous output is captured here together with the valid pulse.
        rvalid_a_d = rd_a_q;
        rvalid_b_d = rd_b_q;
        if (rd_a_q || rd_b_q) begin
            rdata_d = ram_do_i;
        end else begin
            rdata_d = rdata_q;
        end

        case (state_q)
            ST_CLR: begin
                ram_ad_d  = cnt_q;
                ram_di_d  = CLEAR_DATA;
                ram_wre_d = 1'b1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_CLR;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (xfer_a_s) begin
                    ram_ad_d  = a_if.addr;
                    ram_di_d  = a_if.wdata;
                    ram_wre_d = a_if.we;
                    rd_a_d    = ~a_if.we;
                    ptr_b_d   = 1'b1;
                end else if (xfer_b_s) begin
                    ram_ad_d  = b_if.addr;
                    ram_di_d  = b_if.wdata;
                    ram_wre_d = b_if.we;
                    rd_b_d    = ~b_if.we;
                    ptr_b_d   = 1'b0;
                end else begin
                    ram_wre_d = 1'b0;
                end
            end
            default: begin
                state_d = RESET_STATE_C;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ck_i) begin
        if (!rstn_i) begin
            state_q    <= RESET_STATE_C;
            cnt_q      <= 4'd0;
            ptr_b_q    <= 1'b0;
            ram_ad_q   <= 4'd0;
            ram_di_q   <= 2'b00;
            ram_wre_q  <= 1'b0;
            ram_wpe_q  <= 1'b0;
            rd_a_q     <= 1'b0;
            rd_b_q     <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_b_q    <= ptr_b_d;
            ram_ad_q   <= ram_ad_d;
            ram_di_q   <= ram_di_d;
            ram_wre_q  <= ram_wre_d;
            ram_wpe_q  <= ram_wpe_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_q    <= rdata_d;
        end
    end

    assign a_if.gnt    = gnt_s[0];
    assign b_if.gnt    = gnt_s[1];
    assign a_if.rvalid = rvalid_a_q;
    assign b_if.rvalid = rvalid_b_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q == ST_CLR);
    assign ram_ad_o    = ram_ad_q;
    assign ram_di_o    = ram_di_q;
    assign ram_wre_o   = ram_wre_q;
    assign ram_wpe_o   = ram_wpe_q;

endmodule

// File: tb/tb_spr16x2_arb.sv
// Directed bench for spr16x2_arb: a round-robin instance with clear data
// 2'b10 wired to a behavioural SPR16X2 model, plus a FIXED-mode instance
// without post-reset clear used for grant checks.
module tb_spr16x2_arb;

    logic ck_s = 1'b0;
    always #5 ck_s = ~ck_s;

    logic rstn_s;

    spr16x2_arb_if a_if ();
    spr16x2_arb_if b_if ();
    spr16x2_arb_if fa_if ();
    spr16x2_arb_if fb_if ();

    logic [1:0] rdata_s, ram_di_s, ram_do_s;
    logic [3:0] ram_ad_s;
    logic       busy_s, wre_s, wpe_s;

    logic [1:0] rdata_fx_s, ram_di_fx_s, ram_do_fx_s;
    logic [3:0] ram_ad_fx_s;
    logic       busy_fx_s, wre_fx_s, wpe_fx_s;

    assign ram_do_fx_s = 2'b00;

    spr16x2_arb #(.CLEAR_ON_RESET(1'b1), .CLEAR_DATA(2'b10), .ARB_MODE("RR")) dut (
        .ck_i(ck_s), .rstn_i(rstn_s), .a_if(a_if), .b_if(b_if),
        .rdata_o(rdata_s), .busy_o(busy_s), .ram_ad_o(ram_ad_s), .ram_di_o(ram_di_s),
        .ram_wre_o(wre_s), .ram_wpe_o(wpe_s), .ram_do_i(ram_do_s)
    );

    spr16x2_arb #(.CLEAR_ON_RESET(1'b0), .CLEAR_DATA(2'b00), .ARB_MODE("FIXED")) dut_fx (
        .ck_i(ck_s), .rstn_i(rstn_s), .a_if(fa_if), .b_if(fb_if),
        .rdata_o(rdata_fx_s), .busy_o(busy_fx_s), .ram_ad_o(ram_ad_fx_s), .ram_di_o(ram_di_fx_s),
        .ram_wre_o(wre_fx_s), .ram_wpe_o(wpe_fx_s), .ram_do_i(ram_do_fx_s)
    );

    // SPR16X2 model: write sampled on the rising edge, committed on the
    // following falling edge; asynchronous read.
    logic [1:0] mem_r [16];
    logic       pend_we_r;
    logic [3:0] pend_ad_r;
    logic [1:0] pend_di_r;

    always @(posedge ck_s) begin
        pend_we_r <= wre_s & wpe_s;
        pend_ad_r <= ram_ad_s;
        pend_di_r <= ram_di_s;
    end

    always @(negedge ck_s) begin
        if (pend_we_r === 1'b1) mem_r[pend_ad_r] <= pend_di_r;
    end

    assign ram_do_s = mem_r[ram_ad_s];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck_s);
        #2;
    endtask

    task automatic idle_all();
        a_if.req = 1'b0;  b_if.req = 1'b0;
        fa_if.req = 1'b0; fb_if.req = 1'b0;
    endtask

    // 16 back-to-back A reads of addresses 0..15; expected word is either
    // the clear value or the low two address bits.
    task automatic rd_burst_a(input logic use_idx);
        int gmiss;
        logic [1:0] e;
        gmiss = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                a_if.req  = 1'b1;
                a_if.we   = 1'b0;
                a_if.addr = 4'(i);
                #1;
                if (a_if.gnt !== 1'b1) gmiss++;
            end else begin
                a_if.req = 1'b0;
            end
            step();
            if (i > 0) begin
                e = use_idx ? 2'(i - 1) : 2'b10;
                chk("burst_rvalid", 32'(a_if.rvalid), 32'd1);
                chk("burst_rdata", 32'(rdata_s), 32'(e));
            end
        end
        chk("burst_gnt_miss", 32'(gmiss), 32'd0);
        step();
        chk("burst_rvalid_end", 32'(a_if.rvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int gnt_in_clr;
        int gmiss;

        rstn_s = 1'b0;
        a_if.req = 1'b0;  a_if.we = 1'b0;  a_if.addr = 4'd0;  a_if.wdata = 2'b00;
        b_if.req = 1'b0;  b_if.we = 1'b0;  b_if.addr = 4'd0;  b_if.wdata = 2'b00;
        fa_if.req = 1'b0; fa_if.we = 1'b0; fa_if.addr = 4'd0; fa_if.wdata = 2'b00;
        fb_if.req = 1'b0; fb_if.we = 1'b0; fb_if.addr = 4'd0; fb_if.wdata = 2'b00;

        // ---- reset values, with A requesting on both instances
        a_if.req = 1'b1;
        fa_if.req = 1'b1;
        step();
        step();
        chk("rst_ram_ad", 32'(ram_ad_s), 32'd0);
        chk("rst_ram_di", 32'(ram_di_s), 32'd0);
        chk("rst_ram_wre", 32'(wre_s), 32'd0);
        chk("rst_ram_wpe", 32'(wpe_s), 32'd0);
        chk("rst_rdata", 32'(rdata_s), 32'd0);
        chk("rst_rvalid_a", 32'(a_if.rvalid), 32'd0);
        chk("rst_gnt_a", 32'(a_if.gnt), 32'd0);
        chk("rst_busy", 32'(busy_s), 32'd1);
        chk("rst_fx_gnt_a", 32'(fa_if.gnt), 32'd0);
        fa_if.req = 1'b0;

        // ---- clear sequence: BUSY for exactly 16 cycles, no grant
        rstn_s = 1'b1;
        busy_cnt = 0;
        gnt_in_clr = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_s) busy_cnt++;
            if (busy_s && a_if.gnt) gnt_in_clr++;
            if (c == 1) begin
                chk("clr_first_ad", 32'(ram_ad_s), 32'd0);
                chk("clr_first_wre", 32'(wre_s), 32'd1);
                chk("clr_first_di", 32'(ram_di_s), 32'd2);
            end
            if (c == 2) chk("clr_second_ad", 32'(ram_ad_s), 32'd1);
            if (c == 16) chk("clr_last_ad", 32'(ram_ad_s), 32'd15);
            if (!busy_s) a_if.req = 1'b0;
            step();
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("clr_gnt_seen", 32'(gnt_in_clr), 32'd0);
        chk("fx_no_clear_busy", 32'(busy_fx_s), 32'd0);
        chk("run_wpe", 32'(wpe_s), 32'd1);
        rd_burst_a(1'b0);

        // ---- write then read-after-write on A
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 4'd5; a_if.wdata = 2'b11;
        #1;
        chk("raw_gnt", 32'(a_if.gnt), 32'd1);
        step();
        chk("raw_ram_ad", 32'(ram_ad_s), 32'd5);
        chk("raw_ram_wre", 32'(wre_s), 32'd1);
        a_if.we = 1'b0;
        step();
        chk("raw_rvalid_early", 32'(a_if.rvalid), 32'd0);
        a_if.req = 1'b0;
        step();
        chk("raw_rvalid", 32'(a_if.rvalid), 32'd1);
        chk("raw_rdata", 32'(rdata_s), 32'd3);
        step();
        chk("raw_rvalid_pulse", 32'(a_if.rvalid), 32'd0);

        // ---- 16 B writes addr i / data i[1:0], then 16 A reads
        gmiss = 0;
        for (int i = 0; i < 16; i++) begin
            b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 4'(i); b_if.wdata = 2'(i);
            #1;
            if (b_if.gnt !== 1'b1) gmiss++;
            step();
        end
        b_if.req = 1'b0;
        chk("bwr_gnt_miss", 32'(gmiss), 32'd0);
        rd_burst_a(1'b1);

        // ---- same-cycle A read / B write to addr 3; B transfer first moves pointer to A
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 4'd3; b_if.wdata = 2'b10;
        step();
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 4'd3;
        b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 4'd3; b_if.wdata = 2'b01;
        #1;
        chk("col_gnt_a", 32'(a_if.gnt), 32'd1);
        chk("col_gnt_b", 32'(b_if.gnt), 32'd0);
        step();
        a_if.req = 1'b0;
        #1;
        chk("col_gnt_b_next", 32'(b_if.gnt), 32'd1);
        step();
        chk("col_rvalid", 32'(a_if.rvalid), 32'd1);
        chk("col_old_data", 32'(rdata_s), 32'd2);
        b_if.req = 1'b0;
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 4'd3;
        step();
        a_if.req = 1'b0;
        step();
        chk("col_new_rvalid", 32'(a_if.rvalid), 32'd1);
        chk("col_new_data", 32'(rdata_s), 32'd1);

        // ---- reset right after a read transfer
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 4'd7;
        step();
        a_if.req = 1'b0;
        rstn_s = 1'b0;
        step();
        chk("mid_rst_rvalid", 32'(a_if.rvalid), 32'd0);
        chk("mid_rst_rdata", 32'(rdata_s), 32'd0);
        chk("mid_rst_ad", 32'(ram_ad_s), 32'd0);
        chk("mid_rst_wre", 32'(wre_s), 32'd0);
        chk("mid_rst_wpe", 32'(wpe_s), 32'd0);
        chk("mid_rst_busy", 32'(busy_s), 32'd1);
        rstn_s = 1'b1;
        step();
        chk("mid_clr_ad0", 32'(ram_ad_s), 32'd0);
        chk("mid_clr_wre", 32'(wre_s), 32'd1);
        chk("mid_clr_rvalid", 32'(a_if.rvalid), 32'd0);
        step();
        chk("mid_clr_ad1", 32'(ram_ad_s), 32'd1);
        for (int c = 0; c < 40 && busy_s; c++) step();
        chk("mid_clr_done", 32'(busy_s), 32'd0);

        // ---- both requesting continuously: RR alternates from A, FIXED always A
        a_if.req = 1'b1;  a_if.we = 1'b0;  a_if.addr = 4'd0;
        b_if.req = 1'b1;  b_if.we = 1'b0;  b_if.addr = 4'd1;
        fa_if.req = 1'b1; fb_if.req = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_gnt_a", 32'(a_if.gnt), 32'((g % 2) == 0));
            chk("rr_gnt_b", 32'(b_if.gnt), 32'((g % 2) == 1));
            chk("fx_gnt_a", 32'(fa_if.gnt), 32'd1);
            chk("fx_gnt_b", 32'(fb_if.gnt), 32'd0);
            step();
        end
        idle_all();
        step();
        step();
        a_if.req = 1'b1; b_if.req = 1'b1;
        fb_if.req = 1'b1;
        #1;
        chk("rr_idle_keep_b", 32'(b_if.gnt), 32'd1);
        chk("rr_idle_keep_a", 32'(a_if.gnt), 32'd0);
        chk("fx_single_b", 32'(fb_if.gnt), 32'd1);
        step();
        idle_all();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
